// File: rtl/product_accumulator_if.sv
// Product-in / frame-sum-out stream pair shared by the accumulator and its neighbours.
// Both directions follow valid/ready: a beat moves on a rising edge where valid and ready are both high.
interface product_accumulator_if #(
  parameter int PROD_W = 8,
  parameter int ACC_W  = 16,
  parameter int LEN_W  = 4
);
  logic              p_valid;
  logic              p_ready;
  logic [PROD_W-1:0] p_data;
  logic              p_last;
  logic              sum_valid;
  logic              sum_ready;
  logic [ACC_W-1:0]  sum_data;
  logic [LEN_W-1:0]  sum_count;
  logic              sum_ovf;

  modport master (
    output p_valid, p_data, p_last, sum_ready,
    input  p_ready, sum_valid, sum_data, sum_count, sum_ovf
  );

  modport slave (
    input  p_valid, p_data, p_last, sum_ready,
    output p_ready, sum_valid, sum_data, sum_count, sum_ovf
  );
endinterface

// File: rtl/product_accumulator.sv
// Sums a frame of unsigned products (ended by p_last) and offers sum, term count and
// a sticky wrap flag on the result stream; input is stalled while a result is held.
module product_accumulator #(
  parameter int PROD_W = 8,
  parameter int ACC_W  = 16,
  parameter int LEN_W  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  product_accumulator_if.slave bus,
  output logic [1:0]           state_o
);
  localparam logic [1:0] ST_INIT = 2'd0;
  localparam logic [1:0] ST_ACC  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W-1:0] res_data_q, res_data_d;
  logic [LEN_W-1:0] res_cnt_q, res_cnt_d;
  logic             res_ovf_q, res_ovf_d;

  logic             xfer;
  logic [ACC_W:0]   sum_ext;
  logic [LEN_W-1:0] cnt_inc;

  assign xfer    = bus.p_valid && (state_q == ST_ACC);
  // One extra bit catches the carry out of the accumulator for the sticky flag.
  assign sum_ext = {1'b0, acc_q} + {{(ACC_W + 1 - PROD_W){1'b0}}, bus.p_data};
  assign cnt_inc = (cnt_q == {LEN_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    res_data_d = res_data_q;
    res_cnt_d  = res_cnt_q;
    res_ovf_d  = res_ovf_q;
    case (state_q)
      ST_INIT: state_d = ST_ACC;
      ST_ACC: begin
        if (xfer) begin
          acc_d = sum_ext[ACC_W-1:0];
          ovf_d = ovf_q | sum_ext[ACC_W];
          cnt_d = cnt_inc;
          if (bus.p_last) begin
            state_d    = ST_HOLD;
            res_data_d = sum_ext[ACC_W-1:0];
            res_cnt_d  = cnt_inc;
            res_ovf_d  = ovf_q | sum_ext[ACC_W];
          end
        end
      end
      ST_HOLD: begin
        if (bus.sum_ready) begin
          state_d = ST_ACC;
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_INIT;
      acc_q      <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      res_data_q <= '0;
      res_cnt_q  <= '0;
      res_ovf_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      res_data_q <= res_data_d;
      res_cnt_q  <= res_cnt_d;
      res_ovf_q  <= res_ovf_d;
    end
  end

  assign bus.p_ready   = (state_q == ST_ACC);
  assign bus.sum_valid = (state_q == ST_HOLD);
  assign bus.sum_data  = res_data_q;
  assign bus.sum_count = res_cnt_q;
  assign bus.sum_ovf   = res_ovf_q;
  assign state_o       = state_q;
endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator: a 16-bit and an 8-bit accumulator instance,
// expected frame results queued at stimulus time and popped by per-instance monitors.
module tb_product_accumulator;
  localparam int PROD_W = 8;
  localparam int LEN_W  = 4;
  localparam int ACC_A  = 16;
  localparam int ACC_B  = 8;
  localparam int WA     = ACC_A + LEN_W + 1;
  localparam int WB     = ACC_B + LEN_W + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  product_accumulator_if #(.PROD_W(PROD_W), .ACC_W(ACC_A), .LEN_W(LEN_W)) if_a ();
  product_accumulator_if #(.PROD_W(PROD_W), .ACC_W(ACC_B), .LEN_W(LEN_W)) if_b ();
  logic [1:0] state_a, state_b;

  product_accumulator #(.PROD_W(PROD_W), .ACC_W(ACC_A), .LEN_W(LEN_W)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(if_a.slave), .state_o(state_a)
  );
  product_accumulator #(.PROD_W(PROD_W), .ACC_W(ACC_B), .LEN_W(LEN_W)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(if_b.slave), .state_o(state_b)
  );

  logic [WA-1:0] exp_q[$];
  logic [WB-1:0] exp_b_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic set_p(input bit sel, input logic v, input logic [7:0] d, input logic l);
    if (sel) begin
      if_b.p_valid = v; if_b.p_data = d; if_b.p_last = l;
    end else begin
      if_a.p_valid = v; if_a.p_data = d; if_a.p_last = l;
    end
  endtask

  // Present one term and hold it until accepted; returns #1 after the accepting edge.
  task automatic send(input bit sel, input logic [7:0] d, input logic l);
    logic rdy;
    int   budget;
    budget = 20;
    set_p(sel, 1'b1, d, l);
    do begin
      @(negedge clk);
      rdy = sel ? if_b.p_ready : if_a.p_ready;
      @(posedge clk);
      #1;
      budget--;
    end while (!rdy && budget > 0);
    chk("xfer_ready", rdy, 1);
    set_p(sel, 1'b0, 8'hAA, 1'b0);
  endtask

  task automatic push_a(input int sum, input int cnt, input bit ovf);
    exp_q.push_back({ovf, cnt[LEN_W-1:0], sum[ACC_A-1:0]});
  endtask

  task automatic push_b(input int sum, input int cnt, input bit ovf);
    exp_b_q.push_back({ovf, cnt[LEN_W-1:0], sum[ACC_B-1:0]});
  endtask

  always @(negedge clk) begin
    if (rst_n && if_a.sum_valid && if_a.sum_ready) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_result_a actual=%0d expected=none", if_a.sum_data);
      end else begin
        chk("result_a", {if_a.sum_ovf, if_a.sum_count, if_a.sum_data}, exp_q.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && if_b.sum_valid && if_b.sum_ready) begin
      if (exp_b_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_result_b actual=%0d expected=none", if_b.sum_data);
      end else begin
        chk("result_b", {if_b.sum_ovf, if_b.sum_count, if_b.sum_data}, exp_b_q.pop_front());
      end
    end
  end

  initial begin
    set_p(0, 1'b0, 8'h00, 1'b0);
    set_p(1, 1'b0, 8'h00, 1'b0);
    if_a.sum_ready = 1'b1;
    if_b.sum_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_p_ready", if_a.p_ready, 0);
    chk("rst_sum_valid", if_a.sum_valid, 0);
    chk("rst_sum_data", if_a.sum_data, 0);
    chk("rst_sum_count", if_a.sum_count, 0);
    chk("rst_sum_ovf", if_a.sum_ovf, 0);
    chk("rst_state", state_a, 0);
    rst_n = 1'b1;
    chk("init_p_ready", if_a.p_ready, 0);
    @(posedge clk);
    #1;
    chk("acc_p_ready", if_a.p_ready, 1);
    chk("acc_state", state_a, 1);

    // Frame 110+15+84+150 = 359, consumer ready
    push_a(359, 4, 0);
    send(0, 8'd110, 0);
    send(0, 8'd15, 0);
    send(0, 8'd84, 0);
    send(0, 8'd150, 1);
    chk("t1_latency_valid", if_a.sum_valid, 1);
    chk("t1_hold_p_ready", if_a.p_ready, 0);
    @(posedge clk);
    #1;
    chk("t1_after_valid", if_a.sum_valid, 0);
    chk("t1_after_p_ready", if_a.p_ready, 1);

    // Same frame with the consumer stalling for 5 cycles
    if_a.sum_ready = 1'b0;
    push_a(359, 4, 0);
    send(0, 8'd110, 0);
    send(0, 8'd15, 0);
    send(0, 8'd84, 0);
    send(0, 8'd150, 1);
    for (int i = 0; i < 5; i++) begin
      chk("t2_held_valid", if_a.sum_valid, 1);
      chk("t2_held_data", if_a.sum_data, 359);
      chk("t2_held_p_ready", if_a.p_ready, 0);
      @(posedge clk);
      #1;
    end
    if_a.sum_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("t2_release_p_ready", if_a.p_ready, 1);
    chk("t2_release_valid", if_a.sum_valid, 0);

    // 8-bit accumulator wraps: 150+150 = 300 -> 44 with ovf; next frame clean
    push_b(44, 2, 1);
    send(1, 8'd150, 0);
    send(1, 8'd150, 1);
    chk("t3_latency_valid", if_b.sum_valid, 1);
    @(posedge clk);
    #1;
    push_b(10, 1, 0);
    send(1, 8'd10, 1);
    chk("t3b_latency_valid", if_b.sum_valid, 1);
    @(posedge clk);
    #1;

    // Gapped input; idle cycles carry p_last=1 with p_valid=0, which must be ignored
    push_a(765, 3, 0);
    for (int i = 0; i < 3; i++) begin
      set_p(0, 1'b0, 8'hFF, 1'b1);
      @(posedge clk);
      #1;
      send(0, 8'd255, (i == 2));
    end
    @(posedge clk);
    #1;

    // Count saturates at 15 while the sum keeps going
    push_a(20, 15, 0);
    for (int i = 0; i < 20; i++) send(0, 8'd1, (i == 19));
    @(posedge clk);
    #1;

    // Reset mid-frame discards the partial sum
    send(0, 8'd5, 0);
    send(0, 8'd6, 0);
    rst_n = 1'b0;
    #2;
    chk("t6_rst_p_ready", if_a.p_ready, 0);
    chk("t6_rst_valid", if_a.sum_valid, 0);
    chk("t6_rst_state", state_a, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("t6_init_p_ready", if_a.p_ready, 0);
    @(posedge clk);
    #1;
    chk("t6_acc_p_ready", if_a.p_ready, 1);
    push_a(7, 1, 0);
    send(0, 8'd7, 1);
    chk("t6_latency_valid", if_a.sum_valid, 1);

    repeat (3) @(posedge clk);
    #1;
    chk("queue_a_drained", exp_q.size(), 0);
    chk("queue_b_drained", exp_b_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
